// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM CPU: FSM state encodings, opcode nibbles and
// the operand-length decode used by the fetch unit.
package hrm_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StOpLat   = 3'd1,
        StArgWait = 3'd2,
        StArgLat  = 3'd3,
        StDone    = 3'd4
    } fetch_state_t;

    // Opcode high nibbles
    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPP    = 4'h6;
    localparam logic [3:0] OP_BUMPN    = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hF;

    // Indirect-addressing flag; irrelevant to the operand decode
    localparam int unsigned IND_BIT = 3;

    // COPYFROM..JUMPN carry a one-byte operand; everything else stands alone
    function automatic logic has_operand(input logic [7:0] opcode);
        return (opcode[7:4] >= OP_COPYFROM) && (opcode[7:4] <= OP_JUMPN);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, parallel load, increment with natural wrap.
module pc_reg #(
    parameter int unsigned         PC_W     = 8,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] ONE = PC_W'(1);

    // Load has priority over increment; the FSM never asks for both at once
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ONE;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: walks the synchronous program ROM, strobes the opcode
// into the IR and latches an operand byte for opcodes that carry one.
module ifetch
    import hrm_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_addr,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    output logic [7:0]      nIR,
    output logic            wIR,
    output logic [7:0]      rArg,
    output logic            wArg,
    output logic [PC_W-1:0] rPC,
    output logic            busy,
    output logic            fetch_done
);

    fetch_state_t state;
    logic         pc_load;
    logic         pc_inc;

    // Jumps only land in IDLE; PC advances past each byte as it is consumed
    always_comb begin
        pc_load = (state == StIdle) && jmp;
        pc_inc  = (state == StOpLat) || (state == StArgLat);
    end

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (jmp_addr),
        .inc      (pc_inc),
        .pc       (rPC)
    );

    // Sequencer with registered strobes: each strobe is set on entry to its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            wIR        <= 1'b0;
            wArg       <= 1'b0;
            fetch_done <= 1'b0;
            rArg       <= 8'h00;
        end else begin
            wIR        <= 1'b0;
            wArg       <= 1'b0;
            fetch_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (!jmp && fetch) begin
                        state <= StOpLat;
                        wIR   <= 1'b1;
                    end
                end
                StOpLat: begin
                    if (has_operand(rom_data)) begin
                        state <= StArgWait;
                    end else begin
                        state      <= StDone;
                        fetch_done <= 1'b1;
                    end
                end
                StArgWait: begin
                    state <= StArgLat;
                    wArg  <= 1'b1;
                end
                StArgLat: begin
                    rArg       <= rom_data;
                    state      <= StDone;
                    fetch_done <= 1'b1;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Gate the ROM bus so the IR input is quiet outside the write strobe
    always_comb begin
        rom_addr = rPC;
        nIR      = wIR ? rom_data : 8'h00;
        busy     = (state != StIdle);
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a cycle-by-cycle vector table plus a reset-abort sequence.
module tb_ifetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch = 1'b0;
    logic       jmp = 1'b0;
    logic [7:0] jmp_addr = 8'h00;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] nIR;
    logic       wIR;
    logic [7:0] rArg;
    logic       wArg;
    logic [7:0] rPC;
    logic       busy;
    logic       fetch_done;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Synchronous ROM model
    always_ff @(posedge clk) rom_data <= mem[rom_addr];

    ifetch #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch),
        .jmp        (jmp),
        .jmp_addr   (jmp_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .nIR        (nIR),
        .wIR        (wIR),
        .rArg       (rArg),
        .wArg       (wArg),
        .rPC        (rPC),
        .busy       (busy),
        .fetch_done (fetch_done)
    );

    typedef struct {
        logic       rst;
        logic       fetch;
        logic       jmp;
        logic [7:0] jaddr;
        logic       wir;
        logic [7:0] nir;
        logic       warg;
        logic [7:0] rarg;
        logic       done;
        logic       busy;
        logic [7:0] pc;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, settle before checking
    task automatic step(input logic r, input logic f, input logic j, input logic [7:0] a);
        @(negedge clk);
        rst      = r;
        fetch    = f;
        jmp      = j;
        jmp_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " wIR"}, {7'd0, wIR}, {7'd0, v.wir});
        chk({tag, " nIR"}, nIR, v.nir);
        chk({tag, " wArg"}, {7'd0, wArg}, {7'd0, v.warg});
        chk({tag, " rArg"}, rArg, v.rarg);
        chk({tag, " fetch_done"}, {7'd0, fetch_done}, {7'd0, v.done});
        chk({tag, " busy"}, {7'd0, busy}, {7'd0, v.busy});
        chk({tag, " rPC"}, rPC, v.pc);
        chk({tag, " rom_addr"}, rom_addr, v.pc);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(vecs[i].rst, vecs[i].fetch, vecs[i].jmp, vecs[i].jaddr);
            check_all($sformatf("row%0d", i), vecs[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
        mem[8'h00] = 8'h10;  // OUTBOX
        mem[8'h01] = 8'h30;  // COPYTO
        mem[8'h02] = 8'h05;
        mem[8'h40] = 8'h28;  // COPYFROM, indirect
        mem[8'h41] = 8'h07;
        mem[8'hFF] = 8'h80;  // JUMP, operand wraps to address 0

        //         rst   fetch jmp   jaddr   wIR   nIR    wArg  rArg   done  busy  pc
        // reset, then idle
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        // OUTBOX at 0: no operand
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01};
        // COPYTO 5 at 1
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h02};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 8'h03};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0, 8'h03};
        // jmp beats fetch, then indirect COPYFROM 7 at 0x40
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0, 8'h40};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h28, 1'b0, 8'h05, 1'b0, 1'b1, 8'h40};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 1'b1, 8'h41};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b1, 8'h41};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 1'b1, 8'h42};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0, 1'b0, 8'h42};
        // jump to 0xFF, JUMP with operand wrapping to 0; requests while busy ignored
        vecs[18] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0, 1'b0, 8'hFF};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h07, 1'b0, 1'b1, 8'hFF};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0, 1'b1, 8'h00};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 8'h00};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h12, 1'b1, 1'b1, 8'h01};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 1'b0, 1'b0, 8'h01};

        run_rows(0, 17);
        mem[8'h00] = 8'h12;  // operand byte for the wrapped JUMP
        run_rows(18, 23);

        // Reset during ARG_WAIT abandons the COPYTO at address 1
        step(1'b0, 1'b1, 1'b0, 8'h00);
        v = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 8'h12, 1'b0, 1'b1, 8'h01};
        check_all("abort oplat", v);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        v = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 1'b0, 1'b1, 8'h02};
        check_all("abort argwait", v);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        v = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        check_all("abort reset", v);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            v = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
            check_all($sformatf("abort after%0d", k), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch unit for the HRM CPU. It is the writer side of the instruction register interface.
- It owns the program counter and reads the synchronous program ROM.
- Per fetch request it drives an opcode byte on nIR with a one-cycle wIR strobe, then fetches the operand byte when the opcode needs one.
- It sits between the control unit (fetch/jump requests), the program ROM and the IR / operand registers.

Parameters:
- PC_W, 8, program counter and ROM address width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch  input  1  control unit request to fetch the next instruction; sampled only in IDLE.
- jmp  input  1  load PC from jmp_addr; sampled only in IDLE; has priority over fetch.
- jmp_addr  input  PC_W  jump target.
- rom_addr  output  PC_W  ROM read address; always equal to rPC.
- rom_data  input  8  ROM read data; valid one cycle after rom_addr is sampled.
- nIR  output  8  opcode byte to the IR; equals rom_data while wIR=1, else 0.
- wIR  output  1  IR write strobe; exactly one cycle per fetch.
- rArg  output  8  registered operand byte.
- wArg  output  1  one-cycle pulse in the cycle rArg takes a new value.
- rPC  output  PC_W  current program counter.
- busy  output  1  high whenever the state is not IDLE.
- fetch_done  output  1  one-cycle pulse when the instruction (and operand, if any) is complete.

Behaviour:
- Reset: on rst=1 at a clock edge:
  - state=IDLE, rPC=RESET_PC, rArg=0.
  - wIR=0, wArg=0, fetch_done=0, busy=0.
  - Reset is honoured in any state; an in-flight fetch is abandoned and produces no wIR/wArg/fetch_done after the reset edge.
- States: IDLE, OP_LAT, ARG_WAIT, ARG_LAT, DONE. Encodings live in the package.
- IDLE:
  - jmp=1: rPC<=jmp_addr, stay in IDLE. A simultaneous fetch is ignored.
  - else fetch=1: go to OP_LAT. At this edge the ROM samples rom_addr=rPC.
- OP_LAT:
  - rom_data=mem[rPC]; drive nIR=rom_data, wIR=1; rPC<=rPC+1.
  - If the opcode needs an operand, go to ARG_WAIT; otherwise go to DONE.
- ARG_WAIT: ROM samples the incremented rPC; no outputs asserted; go to ARG_LAT.
- ARG_LAT: rArg<=rom_data, wArg=1, rPC<=rPC+1, go to DONE.
- DONE: fetch_done=1 for one cycle, go to IDLE.
- Operand rule: an operand is needed iff opcode[7:4] is in 0x2..0xA (COPYFROM, COPYTO, ADD, SUB, BUMP+, BUMP-, JUMP, JUMPZ, JUMPN). INBOX 0x0x, OUTBOX 0x1x and HALT 0xFx take no operand. The indirect bit opcode[3] does not affect the rule.
- Latency:
  - No-operand instruction: fetch sampled at edge E; wIR in cycle E+1; fetch_done in cycle E+2; IDLE again at E+3.
  - Operand instruction: wIR at E+1, wArg at E+3, fetch_done at E+4.
- rPC arithmetic: modulo 2^PC_W. 2^PC_W-1 increments to 0, including mid-instruction; the operand is then read from address 0.
- fetch or jmp outside IDLE: ignored, not queued. The control unit must wait for busy=0.
- rArg holds its value until the next wArg. It is not cleared by no-operand fetches.
- nIR must be 0 whenever wIR=0, so IR input traces stay clean.

Decomposition:
- Shared package hrm_pkg holds:
  - state encodings;
  - opcode nibble constants (OP_INBOX=0x0, OP_OUTBOX=0x1 ... OP_JUMPN=0xA, OP_HALT=0xF);
  - IND_BIT=3;
  - function has_operand(opcode).
- Sub-module pc_reg (load/increment counter with wrap, PC_W wide) is natural; the FSM and strobes stay in ifetch.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, no fetch -> rPC=0, rArg=0, busy=0; wIR, wArg and fetch_done never asserted.
- No-operand fetch: ROM[0]=0x10 (OUTBOX), fetch pulse -> wIR=1 with nIR=0x10 one cycle later, fetch_done the next cycle, rPC=1, rArg unchanged.
- Operand fetch: ROM[1]=0x30, ROM[2]=0x05 (COPYTO 5), fetch -> nIR=0x30 with wIR, two cycles later wArg with rArg=0x05, then fetch_done; rPC=3.
- Jump priority: in IDLE assert jmp=1, jmp_addr=0x40 and fetch=1 together -> rPC=0x40, no wIR. Then fetch with ROM[0x40]=0x28 (indirect COPYFROM) and ROM[0x41]=0x07 -> rArg=0x07, rPC=0x42.
- Ignored requests and wrap: PC_W=8, jump to 0xFF, ROM[0xFF]=0x80, ROM[0x00]=0x12. Fetch, and assert fetch and jmp while busy -> operand 0x12 latched from address 0, rPC=0x01; requests made while busy have no effect.
- Reset mid-operation: assert rst in the ARG_WAIT cycle -> next cycle state=IDLE, rPC=0, no wArg or fetch_done pulse afterwards.
